// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and constants for the seven-segment display blocks
package seg7_pkg;

  localparam int DISP_W     = 16;
  localparam int CTRL_BLINK = 0;
  localparam int CTRL_BLANK = 1;

  typedef enum logic [1:0] {
    S_CPU  = 2'd0,
    S_DBG  = 2'd1,
    S_HOLD = 2'd2
  } disp_state_t;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_div.sv
// rtl/seg7_scan_div.sv - scan clock divider with a one-cycle pulse ahead of each scan_clk rise
module seg7_scan_div
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic clr_n,
  output logic scan_clk,
  output logic tick
);

  localparam int            DW       = cnt_width(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          wrap;

  assign wrap = (div_cnt == DIV_LAST);
  // High in the cycle whose closing edge drives scan_clk from 0 to 1.
  assign tick = wrap & ~scan_clk;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      div_cnt  <= '0;
      scan_clk <= 1'b0;
    end else if (wrap) begin
      div_cnt  <= '0;
      scan_clk <= ~scan_clk;
    end else begin
      div_cnt  <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/seg7_disp_arbiter.sv
// rtl/seg7_disp_arbiter.sv - arbitrates the scanner value between CPU register and debug port,
// and produces scan clock and blink/blank control
module seg7_disp_arbiter
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_TICKS = 256,
  parameter int HOLD_TICKS  = 1024
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              cpu_we,
  input  logic [DISP_W-1:0] cpu_data,
  input  logic              cpu_ctrl_we,
  input  logic [1:0]        cpu_ctrl,
  input  logic              dbg_req,
  input  logic [DISP_W-1:0] dbg_data,
  output logic              dbg_gnt,
  output logic              owner,
  output logic [DISP_W-1:0] disp_x,
  output logic              scan_clk,
  output logic              blank
);

  localparam int            BW         = cnt_width(BLINK_TICKS);
  localparam int            HW         = cnt_width(HOLD_TICKS);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);

  logic              tick;
  logic [DISP_W-1:0] cpu_reg;
  logic [1:0]        ctrl;
  disp_state_t       state, next_state;
  logic [HW-1:0]     hold_cnt;
  logic [BW-1:0]     blink_cnt;
  logic              blink_phase;
  logic [DISP_W-1:0] disp_d;
  logic              owner_d;
  logic              gnt_d;
  logic              blank_d;

  seg7_scan_div #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_div (
    .clk      (clk),
    .clr_n    (clr_n),
    .scan_clk (scan_clk),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cpu_reg <= '0;
      ctrl    <= 2'b00;
    end else begin
      if (cpu_we)      cpu_reg <= cpu_data;
      if (cpu_ctrl_we) ctrl    <= cpu_ctrl;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= S_CPU;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      // A CPU write in the same cycle as a request wins; the request is seen again next cycle.
      S_CPU:   if (dbg_req && !cpu_we) next_state = S_DBG;
      S_DBG:   if (!dbg_req)           next_state = S_HOLD;
      S_HOLD: begin
        if (dbg_req)                            next_state = S_DBG;
        else if (tick && hold_cnt == HOLD_LAST) next_state = S_CPU;
      end
      default: next_state = S_CPU;
    endcase
  end

  always_comb begin
    disp_d  = disp_x;
    owner_d = 1'b0;
    gnt_d   = 1'b0;
    case (state)
      S_CPU: disp_d = cpu_reg;
      S_DBG: begin
        owner_d = 1'b1;
        gnt_d   = dbg_req;
        if (dbg_req) disp_d = dbg_data;
      end
      S_HOLD:  owner_d = 1'b1;
      default: disp_d  = cpu_reg;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      disp_x  <= '0;
      owner   <= 1'b0;
      dbg_gnt <= 1'b0;
    end else begin
      disp_x  <= disp_d;
      owner   <= owner_d;
      dbg_gnt <= gnt_d;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hold_cnt <= '0;
    end else if (state != S_HOLD) begin
      hold_cnt <= '0;
    end else if (tick && !dbg_req && hold_cnt != HOLD_LAST) begin
      hold_cnt <= hold_cnt + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!ctrl[CTRL_BLINK]) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + BW'(1);
      end
    end
  end

  assign blank_d = ctrl[CTRL_BLANK] | (ctrl[CTRL_BLINK] & blink_phase);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) blank <= 1'b0;
    else        blank <= blank_d;
  end

endmodule

// File: tb/tb_seg7_disp_arbiter.sv
// tb/tb_seg7_disp_arbiter.sv - directed and randomized bench for seg7_disp_arbiter
module tb_seg7_disp_arbiter;

  localparam int SD = 4;
  localparam int BT = 2;
  localparam int HT = 3;

  localparam int M_CPU  = 0;
  localparam int M_DBG  = 1;
  localparam int M_HOLD = 2;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_data = '0;
  logic        cpu_ctrl_we = 1'b0;
  logic [1:0]  cpu_ctrl = 2'b00;
  logic        dbg_req = 1'b0;
  logic [15:0] dbg_data = '0;
  logic        dbg_gnt;
  logic        owner;
  logic [15:0] disp_x;
  logic        scan_clk;
  logic        blank;

  always #5 clk = ~clk;

  seg7_disp_arbiter #(
    .SCAN_DIV    (SD),
    .BLINK_TICKS (BT),
    .HOLD_TICKS  (HT)
  ) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .cpu_we      (cpu_we),
    .cpu_data    (cpu_data),
    .cpu_ctrl_we (cpu_ctrl_we),
    .cpu_ctrl    (cpu_ctrl),
    .dbg_req     (dbg_req),
    .dbg_data    (dbg_data),
    .dbg_gnt     (dbg_gnt),
    .owner       (owner),
    .disp_x      (disp_x),
    .scan_clk    (scan_clk),
    .blank       (blank)
  );

  int passed = 0;
  int total  = 0;
  int failed = 0;

  int          m_edges;
  int          m_mode;
  int          m_hold_left;
  int          m_en_ticks;
  logic [15:0] m_cpu_reg;
  logic [15:0] m_disp;
  logic [1:0]  m_ctrl;
  logic        m_gnt;
  logic        m_owner;
  logic        m_blank;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_edges     = 0;
    m_mode      = M_CPU;
    m_hold_left = 0;
    m_en_ticks  = 0;
    m_cpu_reg   = '0;
    m_disp      = '0;
    m_ctrl      = 2'b00;
    m_gnt       = 1'b0;
    m_owner     = 1'b0;
    m_blank     = 1'b0;
  endtask

  task automatic check_outputs();
    check("disp_x",   disp_x,   m_disp);
    check("dbg_gnt",  dbg_gnt,  m_gnt);
    check("owner",    owner,    m_owner);
    check("scan_clk", scan_clk, ((m_edges / SD) % 2));
    check("blank",    blank,    m_blank);
  endtask

  // Advance the reference by one clock using the inputs currently applied, then compare.
  task automatic step();
    bit tick;
    bit phase;
    tick  = (((m_edges + 1) % (2 * SD)) == SD);
    phase = (((m_en_ticks / BT) % 2) == 1);
    m_blank = m_ctrl[1] | (m_ctrl[0] & phase);
    case (m_mode)
      M_CPU: begin
        m_disp  = m_cpu_reg;
        m_owner = 1'b0;
        m_gnt   = 1'b0;
        if (dbg_req && !cpu_we) m_mode = M_DBG;
      end
      M_DBG: begin
        m_owner = 1'b1;
        if (dbg_req) begin
          m_gnt  = 1'b1;
          m_disp = dbg_data;
        end else begin
          m_gnt       = 1'b0;
          m_mode      = M_HOLD;
          m_hold_left = HT;
        end
      end
      default: begin
        m_owner = 1'b1;
        m_gnt   = 1'b0;
        if (dbg_req) begin
          m_mode = M_DBG;
        end else if (tick) begin
          m_hold_left--;
          if (m_hold_left == 0) m_mode = M_CPU;
        end
      end
    endcase
    if (m_ctrl[0]) m_en_ticks += int'(tick);
    else           m_en_ticks = 0;
    if (cpu_we)      m_cpu_reg = cpu_data;
    if (cpu_ctrl_we) m_ctrl    = cpu_ctrl;
    m_edges++;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    clr_n = 1'b1;

    steps(4);
    check("scan_rise", scan_clk, 1);
    steps(4);
    check("scan_fall", scan_clk, 0);
    steps(8);

    cpu_we = 1'b1; cpu_data = 16'h1234;
    step();
    cpu_we = 1'b0;
    step();
    check("cpu_disp", disp_x, 16'h1234);
    check("cpu_owner", owner, 0);

    dbg_req = 1'b1; dbg_data = 16'hBEEF;
    cpu_we = 1'b1; cpu_data = 16'h5555;
    step();
    cpu_we = 1'b0;
    step();
    check("collide_disp", disp_x, 16'h5555);
    check("collide_gnt", dbg_gnt, 0);
    step();
    check("grant_gnt", dbg_gnt, 1);
    check("grant_disp", disp_x, 16'hBEEF);
    steps(3);

    dbg_req = 1'b0; dbg_data = 16'h0000;
    step();
    check("release_gnt", dbg_gnt, 0);
    check("release_disp", disp_x, 16'hBEEF);
    check("release_owner", owner, 1);
    steps(28);
    check("hold_done_disp", disp_x, 16'h5555);
    check("hold_done_owner", owner, 0);

    dbg_req = 1'b1; dbg_data = 16'hCAFE;
    steps(4);
    dbg_req = 1'b0;
    steps(11);
    check("hold_owner", owner, 1);
    dbg_req = 1'b1; dbg_data = 16'h0F0F;
    steps(2);
    check("rereq_gnt", dbg_gnt, 1);
    check("rereq_disp", disp_x, 16'h0F0F);
    dbg_req = 1'b0;
    steps(30);

    cpu_ctrl_we = 1'b1; cpu_ctrl = 2'b01;
    step();
    cpu_ctrl_we = 1'b0;
    steps(40);
    cpu_ctrl_we = 1'b1; cpu_ctrl = 2'b10;
    step();
    cpu_ctrl_we = 1'b0;
    steps(3);
    check("force_blank", blank, 1);
    steps(10);
    cpu_ctrl_we = 1'b1; cpu_ctrl = 2'b00;
    step();
    cpu_ctrl_we = 1'b0;
    steps(2);
    check("unblank", blank, 0);
    cpu_ctrl_we = 1'b1; cpu_ctrl = 2'b01;
    step();
    cpu_ctrl_we = 1'b0;
    steps(20);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) dbg_req = ~dbg_req;
      dbg_data    = 16'($urandom);
      cpu_we      = ($urandom_range(0, 7) == 0);
      cpu_data    = 16'($urandom);
      cpu_ctrl_we = ($urandom_range(0, 31) == 0);
      cpu_ctrl    = 2'($urandom_range(0, 3));
      step();
    end
    cpu_we = 1'b0; cpu_ctrl_we = 1'b0;

    dbg_req = 1'b0; cpu_we = 1'b1; cpu_data = 16'hABCD;
    steps(30);
    cpu_we = 1'b0;
    dbg_req = 1'b1; dbg_data = 16'h7777;
    steps(3);
    check("pre_reset_gnt", dbg_gnt, 1);
    #3;
    clr_n = 1'b0;
    #1;
    model_reset();
    check("async_gnt", dbg_gnt, 0);
    check("async_owner", owner, 0);
    check("async_disp", disp_x, 16'h0000);
    dbg_req = 1'b0;
    #2;
    @(negedge clk);
    clr_n = 1'b1;
    steps(4);
    check("post_reset_cpu_reg", disp_x, 16'h0000);
    dbg_req = 1'b1; dbg_data = 16'h1357;
    steps(3);
    check("post_reset_regrant", dbg_gnt, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
